// File: rtl/calc_arbiter.sv
// calc_arbiter: shares one combinational 8-bit calculator between two requesters.
// Each transaction accepts a command word, drives it to the calculator, waits
// SETTLE_CYCLES edges, captures the result and holds it until the winner takes it.
module calc_arbiter #(
    // Edges from calc_in update to calc_out capture; legal range 1..15
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_word,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_word,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] calc_in,
    input  logic [7:0] calc_out,
    output logic       busy,
    output logic       grant_id,
    output logic [7:0] op_count
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   calc_in_q, calc_in_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]   op_count_q, op_count_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                sel_c;
    logic                rsp_taken_c;

    // Pick a requester: a lone valid wins, a tie goes to whoever was not served last
    always_comb begin
        sel_c = ~last_grant_q;
        if (req0_valid && !req1_valid) begin
            sel_c = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            sel_c = 1'b1;
        end
    end

    assign req0_ready  = (state_q == IDLE) && req0_valid && !sel_c;
    assign req1_ready  = (state_q == IDLE) && req1_valid &&  sel_c;
    assign rsp_taken_c = grant_q ? rsp1_ready : rsp0_ready;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            calc_in_q    <= '0;
            rsp_data_q   <= '0;
            op_count_q   <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            calc_in_q    <= calc_in_d;
            rsp_data_q   <= rsp_data_d;
            op_count_q   <= op_count_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state and register updates for accept / settle / response phases
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        calc_in_d    = calc_in_q;
        rsp_data_d   = rsp_data_q;
        op_count_d   = op_count_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    calc_in_d = sel_c ? req1_word : req0_word;
                    grant_d   = sel_c;
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d = calc_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_taken_c) begin
                    last_grant_d = grant_q;
                    op_count_d   = op_count_q + DATA_W'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) &&  grant_q;
    assign busy       = (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign calc_in    = calc_in_q;
    assign grant_id   = grant_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (instance A, SETTLE_CYCLES=1), and a
// slow-settling calculator stub on a second instance (B, SETTLE_CYCLES=4).
module tb_calc_arbiter;

    localparam int unsigned SA = 1;
    localparam int unsigned SB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_req0_valid = 1'b0, a_req1_valid = 1'b0;
    logic       a_req0_ready, a_req1_ready;
    logic [7:0] a_req0_word = 8'h00, a_req1_word = 8'h00;
    logic       a_rsp0_valid, a_rsp1_valid;
    logic       a_rsp0_ready = 1'b0, a_rsp1_ready = 1'b0;
    logic [7:0] a_rsp_data, a_calc_in, a_calc_out, a_op_count;
    logic       a_busy, a_grant_id;

    // Instance B signals
    logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
    logic       b_req0_ready, b_req1_ready;
    logic [7:0] b_req0_word = 8'h00, b_req1_word = 8'h00;
    logic       b_rsp0_valid, b_rsp1_valid;
    logic       b_rsp0_ready = 1'b0, b_rsp1_ready = 1'b0;
    logic [7:0] b_rsp_data, b_calc_in, b_calc_out, b_op_count;
    logic       b_busy, b_grant_id;
    logic [7:0] b_d1, b_d2, b_d3;

    // Instant calculator stub for A
    assign a_calc_out = a_calc_in ^ 8'hFF;

    // Slow calculator stub for B: output reflects calc_in only 3 edges later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_d1 <= 8'h00;
            b_d2 <= 8'h00;
            b_d3 <= 8'h00;
        end else begin
            b_d1 <= b_calc_in;
            b_d2 <= b_d1;
            b_d3 <= b_d2;
        end
    end
    assign b_calc_out = b_d3 ^ 8'hFF;

    calc_arbiter #(.SETTLE_CYCLES(SA)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_word(a_req0_word),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_word(a_req1_word),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready),
        .rsp_data(a_rsp_data), .calc_in(a_calc_in), .calc_out(a_calc_out),
        .busy(a_busy), .grant_id(a_grant_id), .op_count(a_op_count)
    );

    calc_arbiter #(.SETTLE_CYCLES(SB)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_word(b_req0_word),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_word(b_req1_word),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
        .rsp_data(b_rsp_data), .calc_in(b_calc_in), .calc_out(b_calc_out),
        .busy(b_busy), .grant_id(b_grant_id), .op_count(b_op_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model of instance A
    int         cyc = 0;       // index of last clock edge seen by the model
    bit         m_busy;        // a transaction is in flight
    int         m_acc;         // edge index at which it was accepted
    bit         m_owner;       // requester of current/last transaction
    bit         m_last;        // requester served last
    logic [7:0] m_word, m_calc_in, m_rsp_data;
    int         m_ops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_acc = 0; m_owner = 1'b0; m_last = 1'b1;
        m_word = 8'h00; m_calc_in = 8'h00; m_rsp_data = 8'h00; m_ops = 0;
    endtask

    // One clock of instance A: check handshake readiness, advance model, check outputs
    task automatic tick();
        bit sel, r0, r1, rv;
        #1;
        if (a_req0_valid && !a_req1_valid)      sel = 1'b0;
        else if (!a_req0_valid && a_req1_valid) sel = 1'b1;
        else                                    sel = !m_last;
        r0 = !m_busy && a_req0_valid && !sel;
        r1 = !m_busy && a_req1_valid &&  sel;
        chk("req0_ready", a_req0_ready, r0);
        chk("req1_ready", a_req1_ready, r1);
        if (r0 || r1) begin
            m_busy = 1'b1; m_acc = cyc + 1; m_owner = sel;
            m_word = sel ? a_req1_word : a_req0_word;
            m_calc_in = m_word;
        end else if (m_busy && (cyc - m_acc) >= int'(SA) &&
                     (m_owner ? a_rsp1_ready : a_rsp0_ready)) begin
            m_busy = 1'b0; m_last = m_owner; m_ops = (m_ops + 1) % 256;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (m_busy && (cyc - m_acc) == int'(SA)) m_rsp_data = m_word ^ 8'hFF;
        rv = m_busy && (cyc - m_acc) >= int'(SA);
        chk("busy",       a_busy,       m_busy);
        chk("calc_in",    a_calc_in,    m_calc_in);
        chk("rsp0_valid", a_rsp0_valid, rv && !m_owner);
        chk("rsp1_valid", a_rsp1_valid, rv &&  m_owner);
        chk("rsp_data",   a_rsp_data,   m_rsp_data);
        chk("grant_id",   a_grant_id,   m_owner);
        chk("op_count",   a_op_count,   32'(m_ops));
    endtask

    task automatic chk_a_reset_vals(input string tag);
        chk({tag, "_busy"},     a_busy,       1'b0);
        chk({tag, "_calc_in"},  a_calc_in,    8'h00);
        chk({tag, "_rsp_data"}, a_rsp_data,   8'h00);
        chk({tag, "_rsp0_v"},   a_rsp0_valid, 1'b0);
        chk({tag, "_rsp1_v"},   a_rsp1_valid, 1'b0);
        chk({tag, "_grant"},    a_grant_id,   1'b0);
        chk({tag, "_op_count"}, a_op_count,   8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_a_reset_vals("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic a_idle_inputs();
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        a_rsp0_ready = 1'b0; a_rsp1_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] held;
        int         rsp_seen, busy_low, last_rsp_t;
        logic [7:0] exp_data [4];
        logic       exp_grant [4];

        model_reset();
        // Reset values straight out of power-on reset
        #1;
        chk_a_reset_vals("por");
        chk("por_b_busy", b_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Slow calculator on B: capture must wait the full 4 edges
        b_req0_word = 8'h5A; b_req0_valid = 1'b1;
        #1;
        chk("b_req0_ready", b_req0_ready, 1'b1);
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        chk("b_calc_in", b_calc_in, 8'h5A);
        chk("b_busy", b_busy, 1'b1);
        for (int k = 1; k < int'(SB); k++) begin
            @(posedge clk); #1;
            chk("b_rsp0_early", b_rsp0_valid, 1'b0);
        end
        @(posedge clk); #1;
        chk("b_rsp0_valid", b_rsp0_valid, 1'b1);
        chk("b_rsp1_valid", b_rsp1_valid, 1'b0);
        chk("b_rsp_data",   b_rsp_data,   8'hA5);
        b_rsp0_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp0_ready = 1'b0;
        chk("b_busy_done", b_busy, 1'b0);
        chk("b_op_count",  b_op_count, 8'h01);

        // Single request from requester 0
        do_reset();
        a_req0_word = 8'h3C; a_req0_valid = 1'b1;
        #1;
        chk("t1_ready0", a_req0_ready, 1'b1);
        tick();
        a_req0_valid = 1'b0;
        chk("t1_calc_in", a_calc_in, 8'h3C);
        tick();
        chk("t1_rsp0_valid", a_rsp0_valid, 1'b1);
        chk("t1_rsp_data",   a_rsp_data,   8'hC3);
        chk("t1_rsp1_valid", a_rsp1_valid, 1'b0);
        a_rsp0_ready = 1'b1;
        tick();
        a_rsp0_ready = 1'b0;
        chk("t1_op_count", a_op_count, 8'h01);

        // Continuous dual requests from reset: strict alternation
        do_reset();
        a_req0_word = 8'h01; a_req1_word = 8'h02;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_data  = '{8'hFE, 8'hFD, 8'hFE, 8'hFD};
        rsp_seen = 0; busy_low = 0; last_rsp_t = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (!a_busy) busy_low++;
            if (a_rsp0_valid || a_rsp1_valid) begin
                if (rsp_seen < 4) begin
                    chk("t2_grant", a_grant_id, exp_grant[rsp_seen]);
                    chk("t2_data",  a_rsp_data, exp_data[rsp_seen]);
                end
                if (rsp_seen > 0) chk("t2_spacing", 32'(t - last_rsp_t), 32'd3);
                last_rsp_t = t;
                rsp_seen++;
            end
        end
        chk("t2_rsp_count", 32'(rsp_seen), 32'd4);
        chk("t2_busy_low",  32'(busy_low), 32'd4);
        a_idle_inputs();

        // Backpressure on requester 1 while requester 0 waits
        a_req1_word = 8'h77; a_req1_valid = 1'b1;
        tick();
        a_req1_valid = 1'b0;
        tick();
        held = a_rsp_data;
        chk("bp_data", held, 8'h88);
        a_req0_word = 8'h10; a_req0_valid = 1'b1; a_rsp0_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_ready0", a_req0_ready, 1'b0);
            chk("bp_rsp1",   a_rsp1_valid, 1'b1);
            chk("bp_hold",   a_rsp_data,   held);
        end
        a_rsp1_ready = 1'b1;
        tick();
        a_rsp1_ready = 1'b0;
        tick();
        chk("bp_grant0",   a_grant_id, 1'b0);
        chk("bp_calc_in0", a_calc_in,  8'h10);
        a_req0_valid = 1'b0;
        tick();
        tick();
        a_rsp0_ready = 1'b0;

        // Asynchronous reset in the middle of SETTLE
        a_req1_word = 8'h42; a_req1_valid = 1'b1;
        tick();
        a_req1_valid = 1'b0;
        chk("ar_busy_pre", a_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a_reset_vals("ar");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        a_req0_word = 8'hA0; a_req1_word = 8'hB1;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1;
        chk("ar_tie_ready0", a_req0_ready, 1'b1);
        chk("ar_tie_ready1", a_req1_ready, 1'b0);
        tick();
        a_idle_inputs();
        tick();
        a_rsp0_ready = 1'b1;
        tick();
        a_rsp0_ready = 1'b0;

        // 256 back-to-back transactions from requester 1: op_count wraps
        do_reset();
        a_req1_valid = 1'b1; a_rsp1_ready = 1'b1;
        for (int t = 1; t <= 768; t++) begin
            a_req1_word = 8'($urandom);
            tick();
            if (t % 3 == 1) chk("wr_grant1", a_grant_id, 1'b1);
            if (t == 765) chk("wr_op255", a_op_count, 8'hFF);
        end
        chk("wr_op_wrap", a_op_count, 8'h00);
        a_idle_inputs();
        tick();

        // Random traffic checked against the model
        for (int t = 0; t < 400; t++) begin
            a_req0_valid = 1'($urandom_range(0, 1));
            a_req1_valid = 1'($urandom_range(0, 1));
            a_req0_word  = 8'($urandom);
            a_req1_word  = 8'($urandom);
            a_rsp0_ready = ($urandom_range(0, 3) != 0);
            a_rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Sequencer/arbiter that shares the single 8-bit combinational calculator datapath between two requesters.
- Accepts one command word per transaction via valid/ready handshake and drives it onto the calculator input.
- Waits a programmable settle time, captures the calculator output, and returns it to the winning requester via valid/ready response handshake.
- Sits between the top-level pin wrapper (or on-chip command sources) and the calculator instance.

Parameters:
- SETTLE_CYCLES, 1, number of clock edges from calc_in update to calc_out capture; legal range 1..15, 0 illegal.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_word  input  8  requester 0 command word, passed verbatim to calculator
- rsp0_valid  output  1  result valid for requester 0
- rsp0_ready  input  1  requester 0 takes result
- req1_valid / req1_ready / req1_word / rsp1_valid / rsp1_ready: same as requester 0, for requester 1
- rsp_data  output  8  captured result, shared by both response channels
- calc_in  output  8  drive to calculator io_in
- calc_out  input  8  from calculator io_out
- busy  output  1  high when state != IDLE
- grant_id  output  1  requester owning the current or last transaction
- op_count  output  8  completed transactions, wraps

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. All state is cleared immediately on rst_n low.
- Reset values:
  - state=IDLE
  - calc_in=0, rsp_data=0, rsp0_valid=rsp1_valid=0, busy=0
  - grant_id=0, op_count=0
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - sel = req0 if only req0_valid; req1 if only req1_valid; if both valid, sel = ~last_grant.
  - reqN_ready is combinational: reqN_ready = (state==IDLE) && reqN_valid && (sel==N). At most one ready is high per cycle.
  - On the accept edge E (valid&&ready): calc_in <= reqN_word; grant_id <= N; cnt <= SETTLE_CYCLES-1; state -> SETTLE.
  - No request valid: remain in IDLE; calc_in holds its last value.
- SETTLE:
  - If cnt != 0: cnt decrements each edge.
  - If cnt == 0: rsp_data <= calc_out; state -> RESP.
  - Net effect: capture occurs at edge E+SETTLE_CYCLES.
- RESP:
  - rsp{grant_id}_valid=1; the other rsp_valid stays 0.
  - rsp_data is held stable until handshake.
  - On rsp{grant_id}_ready: state -> IDLE; last_grant <= grant_id; op_count <= op_count+1 (mod 256, 255->0).
  - rspN_ready of the non-granted requester is ignored.
  - Stays in RESP indefinitely without ready (backpressure). No new request is accepted while busy.
- calc_in is registered and changes only at an accept edge. The requester may change reqN_word freely after its handshake.
- Latency, accept edge E:
  - rsp_valid high after edge E+SETTLE_CYCLES.
  - Earliest next accept at edge E+SETTLE_CYCLES+2 when rsp_ready is held high.
- Fairness:
  - Under continuous dual requests, grants strictly alternate.
  - A single active requester is served back-to-back (last_grant does not block it).
- Reset mid-transaction (SETTLE or RESP): the in-flight transaction is dropped with no response; op_count returns to 0.
- Requests deasserted in IDLE before ready cause no state change. Valid is not required to be sticky.
- cnt is 4 bits wide.

Test Plan:
- Bench stub calculator calc_out = calc_in ^ 8'hFF. SETTLE_CYCLES=1; req0 sends 8'h3C -> req0_ready for one cycle; calc_in=8'h3C after accept edge; rsp0_valid=1 with rsp_data=8'hC3 exactly 1 edge later; rsp1_valid stays 0; op_count=1 after rsp handshake.
- Both valid continuously from reset (req0_word=8'h01, req1_word=8'h02), rsp_ready tied 1 -> grant order 0,1,0,1; rsp_data sequence FE,FD,FE,FD; accepts 3 cycles apart; busy low exactly 1 cycle between transactions.
- SETTLE_CYCLES=4; stub output changes only 3 cycles after calc_in -> captured rsp_data equals the settled value; rsp_valid rises 4 edges after accept.
- Backpressure: rsp1_ready held 0 for 10 cycles while req0_valid=1 -> rsp1_valid and rsp_data stable, req0_ready=0 throughout; on release, req0 is granted next.
- Assert rst_n low asynchronously mid-SETTLE (between clock edges) -> all outputs reach reset values immediately; no rsp_valid after release; first tie afterwards goes to req0.
- 256 single-requester transactions from req1 -> op_count wraps to 0; req1 granted back-to-back each time.
